// File: rtl/pkt_stream_source.sv
// pkt_stream_source: Avalon-ST packet replay transmitter.
// Host loads a frame image into the word buffer over Avalon-MM, then the
// block streams it as big-endian 32-bit beats, once or repeatedly with an
// optional idle gap between frames.
module pkt_stream_source #(
  parameter int DATAWIDTH          = 32,
  parameter int BUF_DEPTH          = 256,
  parameter int SLAVE_ADDRESSWIDTH = 9
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
  input  logic [DATAWIDTH-1:0]          slave_writedata,
  input  logic                          slave_write,
  input  logic                          slave_read,
  input  logic                          slave_chipselect,
  output logic [DATAWIDTH-1:0]          slave_readdata,
  output logic [DATAWIDTH-1:0]          st_data,
  output logic                          st_valid,
  input  logic                          st_ready,
  output logic                          st_sop,
  output logic                          st_eop,
  output logic [1:0]                    st_empty,
  output logic                          frame_done
);

  localparam int IDX_W   = SLAVE_ADDRESSWIDTH - 1;
  localparam int MAX_LEN = BUF_DEPTH * 4;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  logic [DATAWIDTH-1:0] buf_mem [BUF_DEPTH];

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic                 repeat_q, repeat_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          gap_q, gap_d;
  logic                 len_err_q, len_err_d;
  logic [15:0]          frames_q, frames_d;
  logic [DATAWIDTH-1:0] st_data_q, st_data_d;
  logic                 st_valid_q, st_valid_d;
  logic                 st_sop_q, st_sop_d;
  logic                 st_eop_q, st_eop_d;
  logic [1:0]           st_empty_q, st_empty_d;
  logic                 frame_done_q, frame_done_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;

  logic             wr, rd, is_buf, csr_ok, busy, len_legal;
  logic [1:0]       csr_idx;
  logic [IDX_W-1:0] addr_idx, nxt_idx, last_idx;
  logic [1:0]       empty_val;
  logic             buf_we, start_req, stop_req, load_first, go_quiet;

  assign wr        = slave_chipselect && slave_write;
  assign rd        = slave_chipselect && slave_read;
  assign is_buf    = slave_address[SLAVE_ADDRESSWIDTH-1];
  assign addr_idx  = slave_address[IDX_W-1:0];
  assign csr_idx   = slave_address[1:0];
  assign csr_ok    = !is_buf && (slave_address[IDX_W-1:2] == '0);
  assign busy      = (state_q != ST_IDLE);
  assign len_legal = (len_q != '0) && (32'(len_q) <= 32'(MAX_LEN));
  assign last_idx  = IDX_W'((len_q - 16'd1) >> 2);
  assign empty_val = 2'(3'd4 - {1'b0, len_q[1:0]});
  assign nxt_idx   = idx_q + 1'b1;

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[addr_idx] <= slave_writedata;
  end

  // Next-state: slave register access, FSM and stream beat generation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    repeat_d     = repeat_q;
    len_d        = len_q;
    gap_d        = gap_q;
    len_err_d    = len_err_q;
    frames_d     = frames_q;
    st_data_d    = st_data_q;
    st_valid_d   = st_valid_q;
    st_sop_d     = st_sop_q;
    st_eop_d     = st_eop_q;
    st_empty_d   = st_empty_q;
    frame_done_d = 1'b0;
    rdata_d      = rdata_q;
    buf_we       = 1'b0;
    start_req    = 1'b0;
    stop_req     = 1'b0;
    load_first   = 1'b0;
    go_quiet     = 1'b0;

    if (wr) begin
      if (is_buf) begin
        buf_we = !busy;
      end else if (csr_ok) begin
        case (csr_idx)
          2'd0: begin
            repeat_d  = slave_writedata[1] && !slave_writedata[2];
            start_req = slave_writedata[0] && !busy;
            stop_req  = slave_writedata[2];
          end
          2'd1:    if (!busy) len_d = slave_writedata[15:0];
          2'd2:    len_err_d = 1'b0;
          default: if (!busy) gap_d = slave_writedata[15:0];
        endcase
      end
    end

    if (rd) begin
      rdata_d = '0;
      if (is_buf) begin
        rdata_d = buf_mem[addr_idx];
      end else if (csr_ok) begin
        case (csr_idx)
          2'd0:    rdata_d = DATAWIDTH'({repeat_q, 1'b0});
          2'd1:    rdata_d = DATAWIDTH'(len_q);
          2'd2:    rdata_d = DATAWIDTH'({frames_q, 14'd0, len_err_q, busy});
          default: rdata_d = DATAWIDTH'(gap_q);
        endcase
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (len_legal) load_first = 1'b1;
          else           len_err_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (st_valid_q && st_ready) begin
          if (st_eop_q) begin
            frames_d     = frames_q + 16'd1;
            frame_done_d = 1'b1;
            // repeat_d so a STOP landing on the eop edge still ends the run
            if (repeat_d && gap_q == '0) begin
              load_first = 1'b1;
            end else if (repeat_d) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              go_quiet  = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              go_quiet = 1'b1;
            end
          end else begin
            idx_d      = nxt_idx;
            st_data_d  = buf_mem[nxt_idx];
            st_sop_d   = 1'b0;
            st_eop_d   = (nxt_idx == last_idx);
            st_empty_d = (nxt_idx == last_idx) ? empty_val : 2'd0;
          end
        end
      end
      ST_GAP: begin
        if (stop_req)                state_d    = ST_IDLE;
        else if (gap_cnt_q == 16'd1) load_first = 1'b1;
        else                         gap_cnt_d  = gap_cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_first) begin
      state_d    = ST_SEND;
      idx_d      = '0;
      st_data_d  = buf_mem[0];
      st_valid_d = 1'b1;
      st_sop_d   = 1'b1;
      st_eop_d   = (last_idx == '0);
      st_empty_d = (last_idx == '0) ? empty_val : 2'd0;
    end
    if (go_quiet) begin
      st_valid_d = 1'b0;
      st_sop_d   = 1'b0;
      st_eop_d   = 1'b0;
      st_empty_d = 2'd0;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      repeat_q     <= 1'b0;
      len_q        <= '0;
      gap_q        <= '0;
      len_err_q    <= 1'b0;
      frames_q     <= '0;
      st_data_q    <= '0;
      st_valid_q   <= 1'b0;
      st_sop_q     <= 1'b0;
      st_eop_q     <= 1'b0;
      st_empty_q   <= '0;
      frame_done_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      repeat_q     <= repeat_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      len_err_q    <= len_err_d;
      frames_q     <= frames_d;
      st_data_q    <= st_data_d;
      st_valid_q   <= st_valid_d;
      st_sop_q     <= st_sop_d;
      st_eop_q     <= st_eop_d;
      st_empty_q   <= st_empty_d;
      frame_done_q <= frame_done_d;
      rdata_q      <= rdata_d;
    end
  end

  assign slave_readdata = rdata_q;
  assign st_data        = st_data_q;
  assign st_valid       = st_valid_q;
  assign st_sop         = st_sop_q;
  assign st_eop         = st_eop_q;
  assign st_empty       = st_empty_q;
  assign frame_done     = frame_done_q;

endmodule
